// File: rtl/puc_uart_pkg.sv
// Shared types and ASCII helpers for the register-value UART reporter.
// Holds the byte-serializer state encoding and the hex-digit encoding.
package puc_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_ZERO + {4'h0, nib};
        end
        return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: accepts a byte on valid&ready, start bit appears the next cycle.
// byteReady is high in IDLE and on the final STOP cycle, so back-to-back bytes leave no gap.
module uart_byte_tx
    import puc_uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       isReset,
    input  logic [7:0] byteIn,
    input  logic       byteValid,
    output logic       byteReady,
    output logic       txSerial
);

    localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLOCKS_PER_BIT - 1);

    uart_state_e   state_q;
    logic [CW-1:0] clkCount_q;
    logic [2:0]    bitIndex_q;
    logic [7:0]    shift_q;
    logic          txSerial_q;

    assign byteReady = (state_q == IDLE) || ((state_q == STOP) && (clkCount_q == LAST_CLK));
    assign txSerial  = txSerial_q;

    always_ff @(posedge clock) begin
        if (isReset) begin
            state_q    <= IDLE;
            clkCount_q <= '0;
            bitIndex_q <= '0;
            shift_q    <= '0;
            txSerial_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    txSerial_q <= 1'b1;
                    clkCount_q <= '0;
                    if (byteValid) begin
                        shift_q    <= byteIn;
                        state_q    <= START;
                        txSerial_q <= 1'b0;
                    end
                end
                START: begin
                    if (clkCount_q == LAST_CLK) begin
                        clkCount_q <= '0;
                        bitIndex_q <= '0;
                        state_q    <= DATA;
                        txSerial_q <= shift_q[0];
                    end else begin
                        clkCount_q <= clkCount_q + 1'b1;
                    end
                end
                DATA: begin
                    if (clkCount_q == LAST_CLK) begin
                        clkCount_q <= '0;
                        if (bitIndex_q == 3'd7) begin
                            state_q    <= STOP;
                            txSerial_q <= 1'b1;
                        end else begin
                            bitIndex_q <= bitIndex_q + 1'b1;
                            shift_q    <= {1'b0, shift_q[7:1]};
                            txSerial_q <= shift_q[1];
                        end
                    end else begin
                        clkCount_q <= clkCount_q + 1'b1;
                    end
                end
                STOP: begin
                    if (clkCount_q == LAST_CLK) begin
                        clkCount_q <= '0;
                        // Chain straight into the next start bit when a byte is waiting.
                        if (byteValid) begin
                            shift_q    <= byteIn;
                            state_q    <= START;
                            txSerial_q <= 1'b0;
                        end else begin
                            state_q    <= IDLE;
                            txSerial_q <= 1'b1;
                        end
                    end else begin
                        clkCount_q <= clkCount_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    txSerial_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/register_value_uart_tx.sv
// Reports a CPU register as "HHHH\r\n" over UART whenever it differs from the last value sent.
// Values arriving mid-message are dropped except the one present when the line returns to idle.
module register_value_uart_tx
    import puc_uart_pkg::*;
#(
    parameter int REGISTER_WIDTH = 16,
    parameter int CLOCKS_PER_BIT = 434,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clock,
    input  logic                      isReset,
    input  logic [REGISTER_WIDTH-1:0] register1Value,
    output logic                      txSerial,
    output logic                      busy,
    output logic [COUNT_WIDTH-1:0]    messagesSent
);

    localparam int NUM_DIGITS = REGISTER_WIDTH / 4;
    localparam int NUM_CHARS  = NUM_DIGITS + 2;
    localparam int IW         = $clog2(NUM_CHARS + 1);
    localparam logic [IW-1:0] DONE_IDX  = IW'(NUM_CHARS);
    localparam logic [IW-1:0] CR_IDX    = IW'(NUM_DIGITS);

    logic [REGISTER_WIDTH-1:0] lastSent_q, lastSent_d;
    logic [REGISTER_WIDTH-1:0] buffer_q, buffer_d;
    logic                      busy_q, busy_d;
    logic [IW-1:0]             charIndex_q, charIndex_d;
    logic [COUNT_WIDTH-1:0]    messagesSent_q, messagesSent_d;

    logic       startMsg;
    logic       byteValid;
    logic       byteReady;
    logic [7:0] byteIn;
    logic [7:0] charByte;
    logic [3:0] nibble;

    always_comb begin
        nibble = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (charIndex_q == IW'(i)) begin
                nibble = buffer_q[(NUM_DIGITS-1-i)*4 +: 4];
            end
        end
        if (charIndex_q < CR_IDX) begin
            charByte = nibble_to_ascii(nibble);
        end else if (charIndex_q == CR_IDX) begin
            charByte = ASCII_CR;
        end else begin
            charByte = ASCII_LF;
        end
    end

    // The first digit comes straight from the input so the start bit leaves on the next edge.
    assign startMsg  = !busy_q && (register1Value != lastSent_q);
    assign byteValid = startMsg || (busy_q && (charIndex_q != DONE_IDX));
    assign byteIn    = startMsg ? nibble_to_ascii(register1Value[REGISTER_WIDTH-1 -: 4]) : charByte;

    always_comb begin
        lastSent_d     = lastSent_q;
        buffer_d       = buffer_q;
        busy_d         = busy_q;
        charIndex_d    = charIndex_q;
        messagesSent_d = messagesSent_q;
        if (startMsg) begin
            lastSent_d  = register1Value;
            buffer_d    = register1Value;
            busy_d      = 1'b1;
            charIndex_d = IW'(1);
        end else if (busy_q && byteReady) begin
            if (charIndex_q != DONE_IDX) begin
                charIndex_d = charIndex_q + 1'b1;
            end else begin
                busy_d         = 1'b0;
                messagesSent_d = messagesSent_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (isReset) begin
            lastSent_q     <= '0;
            buffer_q       <= '0;
            busy_q         <= 1'b0;
            charIndex_q    <= '0;
            messagesSent_q <= '0;
        end else begin
            lastSent_q     <= lastSent_d;
            buffer_q       <= buffer_d;
            busy_q         <= busy_d;
            charIndex_q    <= charIndex_d;
            messagesSent_q <= messagesSent_d;
        end
    end

    uart_byte_tx #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_byte_tx (
        .clock    (clock),
        .isReset  (isReset),
        .byteIn   (byteIn),
        .byteValid(byteValid),
        .byteReady(byteReady),
        .txSerial (txSerial)
    );

    assign busy         = busy_q;
    assign messagesSent = messagesSent_q;

endmodule

// File: doc/register_value_uart_tx.md
REGISTER_VALUE_UART_TX -- requirements
Module: register_value_uart_tx

Interface
REQ-001 SHALL have parameter REGISTER_WIDTH, default 16: width of observed CPU register; multiple of 4.
REQ-002 SHALL have parameter CLOCKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200).
REQ-003 SHALL have parameter COUNT_WIDTH, default 16: width of messagesSent.
REQ-004 SHALL have port clock, input, 1: sole clock; all state on rising edge.
REQ-005 SHALL have port isReset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port register1Value, input, REGISTER_WIDTH: CPU register value to report.
REQ-007 SHALL have port txSerial, output, 1: UART line, 8N1, idle high.
REQ-008 SHALL have port busy, output, 1: high while a message is in transmission.
REQ-009 SHALL have port messagesSent, output, COUNT_WIDTH: count of completed messages.

Function
REQ-010 SHALL hold lastSent (REGISTER_WIDTH), the value carried by the most recently started message.
REQ-011 SHALL start a message in IDLE when register1Value != lastSent: capture value into shift buffer, set lastSent, busy=1, start bit on txSerial the next cycle.
REQ-012 SHALL ignore register1Value while busy; on return to IDLE, REQ-011 is re-evaluated on the same cycle, so only the latest differing value is sent and intermediate values are dropped.
REQ-013 SHALL send no message if register1Value has returned to lastSent by the time IDLE is re-entered.
REQ-014 Message SHALL be NUM_DIGITS = REGISTER_WIDTH/4 uppercase hex ASCII chars, most significant nibble first (0-9 -> 0x30-0x39, A-F -> 0x41-0x46), then 0x0D, then 0x0A.
REQ-015 Each char SHALL be one start bit (0), 8 data bits LSB first, one stop bit (1), each held exactly CLOCKS_PER_BIT cycles; no gap between chars.
REQ-016 Byte FSM states SHALL be IDLE, START, DATA, STOP; START->DATA and DATA->STOP after CLOCKS_PER_BIT; DATA repeats 8 times; STOP->START if chars remain, else ->IDLE.
REQ-017 A message SHALL occupy exactly (NUM_DIGITS+2)*10*CLOCKS_PER_BIT cycles with busy high throughout.
REQ-018 busy SHALL fall on the cycle IDLE is re-entered; messagesSent SHALL increment on that same cycle, wrapping modulo 2^COUNT_WIDTH.
REQ-019 txSerial SHALL be registered, driven high in IDLE and STOP.

Reset
REQ-020 isReset SHALL, on the next edge, force IDLE, txSerial=1, busy=0, messagesSent=0, lastSent=0, all counters 0, overriding any other event that cycle.
REQ-021 Reset mid-char SHALL abort the message without completing the char; a non-zero register1Value then starts a fresh message per REQ-011 on the first cycle after isReset deasserts.

Structure
REQ-022 Package puc_uart_pkg SHALL hold the state enum, ASCII constants (CR, LF, '0', 'A') and a nibble-to-ASCII function.
REQ-023 Byte serialization SHALL be sub-module uart_byte_tx (byteIn, byteValid in; byteReady, txSerial out; valid/ready handshake, accept when both high); the top handles change detection, character sequencing and the counter.

Verification (CLOCKS_PER_BIT=4, REGISTER_WIDTH=16, COUNT_WIDTH=4)
REQ-024 Reset, register1Value=0x0000 for 200 cycles -> txSerial=1, busy=0, messagesSent=0 throughout.
REQ-025 register1Value=0x1A2F -> bytes 0x31,0x41,0x32,0x46,0x0D,0x0A decoded; busy high exactly 240 cycles; messagesSent=1.
REQ-026 0x0001, then 0x0002 at cycle 50, then 0x0003 at cycle 100 -> "0001\r\n" then "0003\r\n" back-to-back; 0x0002 never sent; messagesSent=2.
REQ-027 0x0005 sent; mid-message input goes 0x0007 then back to 0x0005 -> no second message; busy low after 240 cycles.
REQ-028 isReset pulsed 1 cycle at data bit 5 of char 2 with value 0x00FF -> txSerial=1, busy=0 next cycle; full "00FF\r\n" restarts after release; messagesSent=1.
REQ-029 16 distinct successive values -> messagesSent wraps 15 -> 0.
